// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions for the EX stage.
//   - ALU control codes driven by the ALU control decoder
//   - multiply sequencer state encoding
//   - default datapath width
package alu_defs_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Unsigned shift-add multiply datapath, one multiplier bit per step.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load             capture operands, clear product, counter = DATA_W
//   step             perform one add/shift iteration
//   clr              abandon the operation (clears all state)
//   mcand_in/mplr_in unsigned operand magnitudes
//   cnt_zero         the step taken this cycle brings the counter to zero
//   prod_next        product value after this cycle's step
module mult_shift_add_dp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  clr,
  input  logic [DATA_W-1:0]     mcand_in,
  input  logic [DATA_W-1:0]     mplr_in,
  output logic                  cnt_zero,
  output logic [2*DATA_W-1:0]   prod_next
);

  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplr;
  logic [2*DATA_W-1:0] prod;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W:0]     sum;

  // Upper half accumulates with its carry; the carry becomes the new MSB
  // after the right shift.
  always_comb begin
    sum       = {1'b0, prod[2*DATA_W-1:DATA_W]} + (mplr[0] ? {1'b0, mcand} : '0);
    prod_next = {sum, prod[DATA_W-1:1]};
  end

  assign cnt_zero = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (clr) begin
      mcand <= '0;
      mplr  <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      prod  <= '0;
      cnt   <= CNT_W'(DATA_W);
    end else if (step) begin
      prod  <= prod_next;
      mplr  <= mplr >> 1;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative signed multiply sequencer for the EX stage. Stalls the upstream
// pipeline while the shift-add datapath runs and strobes done_o for one
// cycle with the 2*DATA_W-bit product on {hi_o, result_o}.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   start_i           EX-stage instruction valid
//   ALUCtrl_i         ALU control code; only MULT starts an operation
//   src1_i, src2_i    signed operands
//   flush_i           abort an in-flight operation
//   busy_o            high while iterating
//   stall_o           freeze PC, IF/ID and ID/EX
//   done_o            one-cycle result-valid strobe
//   result_o, hi_o    low / high halves of the last completed product
module mult_seq_ctrl
  import alu_defs_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o
);

  mult_state_e state, state_nxt;

  logic                  acc;
  logic                  load, step, clr;
  logic                  zero_op;
  logic                  cnt_zero;
  logic                  neg;
  logic [DATA_W-1:0]     a_abs, b_abs;
  logic [2*DATA_W-1:0]   prod_next;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [2*DATA_W-1:0]   prod_q;

  // Magnitudes wrap modulo 2^DATA_W, so the most negative value maps to
  // itself and is still correct as an unsigned magnitude.
  assign a_abs   = src1_i[DATA_W-1] ? -src1_i : src1_i;
  assign b_abs   = src2_i[DATA_W-1] ? -src2_i : src2_i;
  assign zero_op = (src1_i == '0) || (src2_i == '0);

  // Reset gates acceptance so stall_o stays low while reset is asserted.
  assign acc = rst_i && (state == ST_IDLE) && start_i &&
               (ALUCtrl_i == ALU_MULT) && !flush_i;

  mult_shift_add_dp #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dp (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .load      (load),
    .step      (step),
    .clr       (clr),
    .mcand_in  (a_abs),
    .mplr_in   (b_abs),
    .cnt_zero  (cnt_zero),
    .prod_next (prod_next)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          load      = 1'b1;
          state_nxt = zero_op ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          clr       = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_zero) state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign prod_fix = neg ? -prod_next : prod_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      neg    <= 1'b0;
      prod_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        neg <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
        if (zero_op) prod_q <= '0;
      end
      if (step && cnt_zero) prod_q <= prod_fix;
    end
  end

  assign busy_o   = (state == ST_RUN);
  assign done_o   = (state == ST_DONE);
  assign stall_o  = acc || ((state == ST_RUN) && !flush_i);
  assign result_o = prod_q[DATA_W-1:0];
  assign hi_o     = prod_q[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'b0000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] res, hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .flush_i   (flush),
    .busy_o    (busy),
    .stall_o   (stall),
    .done_o    (done),
    .result_o  (res),
    .hi_o      (hi)
  );

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  // Reference model: remaining iteration cycles, a pending done strobe and
  // the last delivered product.
  int          run_left = 0;
  bit          m_done   = 1'b0;
  logic [63:0] m_out    = '0;
  logic [63:0] m_pend   = '0;

  function automatic bit model_acc();
    return rst_i && run_left == 0 && !m_done && start && ctrl == 4'b0011 && !flush;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      run_left = 0;
      m_done   = 1'b0;
      m_out    = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (run_left > 0) begin
      if (flush) run_left = 0;
      else begin
        run_left--;
        if (run_left == 0) begin
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end
    end else if (model_acc()) begin
      m_pend = smul(src1, src2);
      if (src1 == 0 || src2 == 0) begin
        m_done = 1'b1;
        m_out  = '0;
      end else begin
        run_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    cmp("busy",  {63'd0, busy},  {63'd0, run_left > 0});
    cmp("stall", {63'd0, stall}, {63'd0, model_acc() || (run_left > 0 && !flush)});
    cmp("done",  {63'd0, done},  {63'd0, m_done});
    cmp("prod",  {hi, res}, m_out);
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int flush_at,
                        input bit hold, input bit noise,
                        output int stalls, output int dones, output int done_cyc,
                        output logic [63:0] got);
    stalls = 0; dones = 0; done_cyc = -1; got = '0;
    start = 1'b1; ctrl = 4'b0011; src1 = a; src2 = b; flush = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        dones++;
        done_cyc = cyc;
        got = {hi, res};
      end
      @(posedge clk); #1;
      if (dones > 0 || !hold) start = 1'b0;
      if (noise && dones == 0 && (flush_at < 0 || cyc + 1 < flush_at)) begin
        start = 1'($urandom_range(0, 1));
        ctrl  = 4'($urandom);
        src1  = $urandom;
        src2  = $urandom;
      end
      flush = (cyc + 1 == flush_at);
      if (dones > 0) break;
      if (flush_at >= 0 && cyc >= flush_at + 3) break;
    end
    flush = 1'b0;
    start = 1'b0;
    cmp("done_count", 64'(dones), (flush_at < 0) ? 64'd1 : 64'd0);
  endtask

  int          st, dn, dc;
  logic [63:0] g;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_busy",  {63'd0, busy},  64'd0);
    cmp("reset_stall", {63'd0, stall}, 64'd0);
    cmp("reset_done",  {63'd0, done},  64'd0);
    cmp("reset_prod",  {hi, res}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    run_op(32'd3, 32'd5, -1, 1'b0, 1'b0, st, dn, dc, g);
    cmp("m3x5_stalls", 64'(st), 64'd33);
    cmp("m3x5_donecyc", 64'(dc), 64'd33);
    cmp("m3x5_prod", g, 64'd15);

    run_op(32'h12345678, 32'd0, -1, 1'b0, 1'b0, st, dn, dc, g);
    cmp("zero_stalls", 64'(st), 64'd1);
    cmp("zero_donecyc", 64'(dc), 64'd1);
    cmp("zero_prod", g, 64'd0);

    run_op(-32'sd7, 32'd6, -1, 1'b0, 1'b0, st, dn, dc, g);
    cmp("m7x6_prod", g, 64'hFFFFFFFF_FFFFFFD6);

    run_op(32'd9, 32'd9, 10, 1'b0, 1'b0, st, dn, dc, g);
    cmp("flush_stalls", 64'(st), 64'd10);
    cmp("flush_keep", {hi, res}, 64'hFFFFFFFF_FFFFFFD6);

    run_op(32'h80000000, 32'h80000000, -1, 1'b0, 1'b0, st, dn, dc, g);
    cmp("minxmin_prod", g, 64'h40000000_00000000);

    run_op(32'd2, 32'd3, -1, 1'b1, 1'b0, st, dn, dc, g);
    cmp("hold_prod", g, 64'd6);
    run_op(32'd4, 32'd4, -1, 1'b0, 1'b0, st, dn, dc, g);
    cmp("b2b_donecyc", 64'(dc), 64'd33);
    cmp("b2b_prod", g, 64'd16);

    // Reset asserted mid-operation, then a non-MULT instruction.
    start = 1'b1; ctrl = 4'b0011; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    cmp("rst_mid_busy",  {63'd0, busy},  64'd0);
    cmp("rst_mid_stall", {63'd0, stall}, 64'd0);
    cmp("rst_mid_done",  {63'd0, done},  64'd0);
    cmp("rst_mid_prod",  {hi, res}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b1;
    start = 1'b1; ctrl = 4'b0010; src1 = 32'd7; src2 = 32'd7;
    @(negedge clk);
    cmp("add_stall", {63'd0, stall}, 64'd0);
    cmp("add_busy",  {63'd0, busy},  64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("add_nodone", {63'd0, done}, 64'd0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int          fa;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h80000000;
        2: a = -32'($urandom_range(1, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      fa = (a != 0 && b != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : -1;
      run_op(a, b, fa, 1'($urandom_range(0, 1)), 1'b1, st, dn, dc, g);
      if (fa < 0) cmp("rand_prod", g, smul(a, b));
      repeat ($urandom_range(0, 3)) begin
        start = 1'($urandom_range(0, 1));
        ctrl  = 4'($urandom);
        if (ctrl == 4'b0011) ctrl = 4'b0111;
        @(posedge clk); #1;
      end
      start = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
